// File: rtl/pragmatic_sched_ctrl_pkg.sv
// Shared types and helpers for the Pragmatic bit-serial MAC sequencer.
// Optional feature macro: PRAG_CYCLE_CNT_EN (issue-cycle counter on the job result).
package prag_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // 1st-stage shifter covers base..base+3, 2nd stage selects one of 8 bit positions
  localparam int WIN1   = 4;
  localparam int SEL1_W = 2;
  localparam int SEL2_W = 3;
  localparam int MASK_W = 1 << SEL2_W;

  // Index of the lowest set bit; 0 when the vector is empty (callers gate on non-empty)
  function automatic logic [SEL2_W-1:0] lowest_set_bit(input logic [MASK_W-1:0] v);
    lowest_set_bit = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set_bit = SEL2_W'(i);
    end
  endfunction

endpackage

// File: rtl/pragmatic_sched_ctrl_if.sv
// Job handshake bundle: job offer (in_*) and result return (out_*).
// Optional feature macro: PRAG_CYCLE_CNT_EN adds out_cycles.
interface pragmatic_sched_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 8,
  parameter int ACC_WIDTH  = 24
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] in_weight;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] in_act;
  logic                                  in_load_accum;
  logic [ACC_WIDTH-1:0]                  in_accum;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [ACC_WIDTH-1:0]                  out_result;
`ifdef PRAG_CYCLE_CNT_EN
  logic [3:0]                            out_cycles;

  modport master (
    output in_valid, in_weight, in_act, in_load_accum, in_accum, out_ready,
    input  in_ready, out_valid, out_result, out_cycles
  );
  modport slave (
    input  in_valid, in_weight, in_act, in_load_accum, in_accum, out_ready,
    output in_ready, out_valid, out_result, out_cycles
  );
`else
  modport master (
    output in_valid, in_weight, in_act, in_load_accum, in_accum, out_ready,
    input  in_ready, out_valid, out_result
  );
  modport slave (
    input  in_valid, in_weight, in_act, in_load_accum, in_accum, out_ready,
    output in_ready, out_valid, out_result
  );
`endif
endinterface

// File: rtl/pragmatic_sched_ctrl_lane_sched.sv
// One lane of the essential-bit scheduler: holds the remaining magnitude bits,
// finds the lowest one, and decides whether it fits in the 1st-stage window.
module prag_lane_sched
  import prag_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_mag,
  input  logic                  issue,
  input  logic [SEL2_W-1:0]     base,
  output logic                  nonempty,
  output logic [SEL2_W-1:0]     pos,
  output logic                  en,
  output logic [SEL1_W-1:0]     sel,
  output logic                  empty_next
);
  logic [DATA_WIDTH-1:0] rem_reg;
  logic [DATA_WIDTH-1:0] rem_next;
  logic [SEL2_W-1:0]     diff;

  assign nonempty   = |rem_reg;
  assign pos        = lowest_set_bit(MASK_W'(rem_reg));
  // base is the minimum over non-empty lanes, so diff never wraps when it matters
  assign diff       = pos - base;
  assign en         = issue && nonempty && (diff < SEL2_W'(WIN1));
  assign sel        = en ? diff[SEL1_W-1:0] : '0;
  assign rem_next   = en ? (rem_reg & ~(DATA_WIDTH'(1) << pos)) : rem_reg;
  assign empty_next = (rem_next == '0);

  // Remaining-bit mask: loaded on accept, one bit retired per enabled issue cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rem_reg <= '0;
    else if (load) rem_reg <= load_mag;
    else           rem_reg <= rem_next;
  end
endmodule

// File: rtl/pragmatic_sched_ctrl.sv
// Pragmatic bit-serial MAC sequencer: decomposes weights into essential bits,
// issues one MAC cycle per common base offset and accumulates the MAC results.
// Optional feature macro: PRAG_CYCLE_CNT_EN exposes the job's issue-cycle count.
module pragmatic_sched_ctrl
  import prag_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int VEC_LENGTH   = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int RESULT_WIDTH = 24
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  pragmatic_sched_ctrl_if.slave                 job,
  output logic                                  mac_en,
  output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] mac_act,
  output logic [VEC_LENGTH-1:0][SEL1_W-1:0]     mac_shift_1st_sel,
  output logic [VEC_LENGTH-1:0]                 mac_shift_1st_en,
  output logic [VEC_LENGTH-1:0]                 mac_is_neg,
  output logic [SEL2_W-1:0]                     mac_shift_2nd_sel,
  output logic                                  mac_shift_2nd_en,
  input  logic signed [RESULT_WIDTH-1:0]        mac_result
);
  state_t                                state_reg;
  logic                                  in_ready_reg;
  logic                                  out_valid_reg;
  logic [ACC_WIDTH-1:0]                  out_result_reg;
  logic [ACC_WIDTH-1:0]                  acc_reg;
  logic                                  mac_en_reg;
  logic                                  issue_d_reg;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_reg;
  logic [VEC_LENGTH-1:0]                 neg_reg;

  logic                                  accept;
  logic                                  issue;
  logic [VEC_LENGTH-1:0]                 neg_in;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] mag_in;
  logic [VEC_LENGTH-1:0]                 lane_nonempty;
  logic [VEC_LENGTH-1:0][SEL2_W-1:0]     lane_pos;
  logic [VEC_LENGTH-1:0]                 lane_en;
  logic [VEC_LENGTH-1:0][SEL1_W-1:0]     lane_sel;
  logic [VEC_LENGTH-1:0]                 lane_empty_next;
  logic [SEL2_W-1:0]                     base_c;
  logic [ACC_WIDTH-1:0]                  mac_ext;
  logic [ACC_WIDTH-1:0]                  acc_init;

  assign accept   = (state_reg == IDLE) && in_ready_reg && job.in_valid;
  assign issue    = (state_reg == ISSUE);
  assign mac_ext  = ACC_WIDTH'(mac_result);
  assign acc_init = job.in_load_accum ? job.in_accum : '0;

  // Sign/magnitude split per lane; -128 maps to magnitude 0x80
  for (genvar gi = 0; gi < VEC_LENGTH; gi++) begin : g_lane
    assign neg_in[gi] = job.in_weight[gi][DATA_WIDTH-1];
    assign mag_in[gi] = neg_in[gi] ? (~job.in_weight[gi] + DATA_WIDTH'(1)) : job.in_weight[gi];

    prag_lane_sched #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (accept),
      .load_mag  (mag_in[gi]),
      .issue     (issue),
      .base      (base_c),
      .nonempty  (lane_nonempty[gi]),
      .pos       (lane_pos[gi]),
      .en        (lane_en[gi]),
      .sel       (lane_sel[gi]),
      .empty_next(lane_empty_next[gi])
    );
  end

  // Common base offset: lowest essential bit among lanes that still have bits
  always_comb begin
    base_c = '1;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      if (lane_nonempty[j] && (lane_pos[j] < base_c)) base_c = lane_pos[j];
    end
  end

  assign mac_en            = mac_en_reg;
  assign mac_shift_2nd_en  = mac_en_reg;
  assign mac_shift_2nd_sel = issue ? base_c : '0;
  assign mac_shift_1st_en  = lane_en;
  assign mac_shift_1st_sel = lane_sel;
  assign mac_act           = act_reg;
  assign mac_is_neg        = neg_reg;
  assign job.in_ready      = in_ready_reg;
  assign job.out_valid     = out_valid_reg;
  assign job.out_result    = out_result_reg;

  // Job FSM with registered handshake outputs; accumulates the result one cycle after each issue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      acc_reg        <= '0;
      mac_en_reg     <= 1'b0;
      issue_d_reg    <= 1'b0;
      act_reg        <= '0;
      neg_reg        <= '0;
    end else begin
      issue_d_reg <= issue;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            act_reg      <= job.in_act;
            neg_reg      <= neg_in;
            acc_reg      <= acc_init;
            in_ready_reg <= 1'b0;
            if (mag_in == '0) begin
              state_reg      <= DONE;
              out_valid_reg  <= 1'b1;
              out_result_reg <= acc_init;
            end else begin
              state_reg  <= ISSUE;
              mac_en_reg <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue_d_reg) acc_reg <= acc_reg + mac_ext;
          if (&lane_empty_next) begin
            state_reg  <= DRAIN;
            mac_en_reg <= 1'b0;
          end
        end
        DRAIN: begin
          acc_reg        <= acc_reg + mac_ext;
          out_result_reg <= acc_reg + mac_ext;
          out_valid_reg  <= 1'b1;
          state_reg      <= DONE;
        end
        DONE: begin
          if (job.out_ready) begin
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            in_ready_reg   <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef PRAG_CYCLE_CNT_EN
  logic [3:0] cyc_cnt_reg;

  // Issue-cycle count for the current job, saturating at 15
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         cyc_cnt_reg <= '0;
    else if (accept)                      cyc_cnt_reg <= '0;
    else if (issue && cyc_cnt_reg != 4'hF) cyc_cnt_reg <= cyc_cnt_reg + 4'd1;
  end

  assign job.out_cycles = cyc_cnt_reg;
`endif

endmodule

// File: tb/tb_pragmatic_sched_ctrl.sv
// Self-checking bench: directed plan cases plus randomized jobs against a
// dot-product / essential-bit reference model; includes a bus-level MAC model.
module tb_pragmatic_sched_ctrl;
  localparam int DW = 8;
  localparam int VL = 8;
  localparam int AW = 24;
  localparam int RW = 24;
  localparam longint AMASK = (64'd1 << AW) - 1;

  typedef logic signed [DW-1:0] vec_t [VL];

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pragmatic_sched_ctrl_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .ACC_WIDTH(AW)) job_if ();

  logic                          mac_en;
  logic [VL-1:0][DW-1:0]         mac_act;
  logic [VL-1:0][1:0]            mac_shift_1st_sel;
  logic [VL-1:0]                 mac_shift_1st_en;
  logic [VL-1:0]                 mac_is_neg;
  logic [2:0]                    mac_shift_2nd_sel;
  logic                          mac_shift_2nd_en;
  logic signed [RW-1:0]          mac_result;

  pragmatic_sched_ctrl #(
    .DATA_WIDTH(DW), .VEC_LENGTH(VL), .ACC_WIDTH(AW), .RESULT_WIDTH(RW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .job              (job_if),
    .mac_en           (mac_en),
    .mac_act          (mac_act),
    .mac_shift_1st_sel(mac_shift_1st_sel),
    .mac_shift_1st_en (mac_shift_1st_en),
    .mac_is_neg       (mac_is_neg),
    .mac_shift_2nd_sel(mac_shift_2nd_sel),
    .mac_shift_2nd_en (mac_shift_2nd_en),
    .mac_result       (mac_result)
  );

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // MAC datapath model: registered sum of shifted/negated activations
  function automatic logic signed [RW-1:0] mac_eval();
    int s = 0;
    for (int j = 0; j < VL; j++) begin
      if (mac_shift_1st_en[j]) begin
        int t = int'($signed(mac_act[j])) <<< mac_shift_1st_sel[j];
        if (mac_is_neg[j]) t = -t;
        s += t;
      end
    end
    s = s <<< mac_shift_2nd_sel;
    return RW'(s);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)    mac_result <= '0;
    else if (mac_en) mac_result <= mac_eval();
  end

  // Reference schedule: per issue, base and expected lane enables/offsets
  int q_base[$];
  int q_en[$];
  int q_sel[$];

  task automatic model_job(input vec_t w);
    int rem[VL];
    int p[VL];
    q_base.delete(); q_en.delete(); q_sel.delete();
    for (int j = 0; j < VL; j++) rem[j] = (w[j] < 0) ? -int'(w[j]) : int'(w[j]);
    forever begin
      int b = 99;
      int en = 0;
      int sel = 0;
      for (int j = 0; j < VL; j++) begin
        p[j] = 0;
        if (rem[j] != 0) begin
          while (((rem[j] >> p[j]) & 1) == 0) p[j]++;
          if (p[j] < b) b = p[j];
        end
      end
      if (b == 99) break;
      for (int j = 0; j < VL; j++) begin
        if (rem[j] != 0 && p[j] - b <= 3) begin
          en |= 1 << j;
          sel |= (p[j] - b) << (2 * j);
          rem[j] &= ~(1 << p[j]);
        end
      end
      q_base.push_back(b); q_en.push_back(en); q_sel.push_back(sel);
    end
  endtask

  task automatic offer_job(input vec_t w, input vec_t a, input bit ld, input int accum);
    int t = 0;
    @(negedge clk);
    for (int j = 0; j < VL; j++) begin
      job_if.in_weight[j] = w[j];
      job_if.in_act[j]    = a[j];
    end
    job_if.in_load_accum = ld;
    job_if.in_accum      = AW'(accum);
    job_if.in_valid      = 1'b1;
    while (!job_if.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) check_val("accept_timeout", 0, 1);
    @(negedge clk);
    job_if.in_valid = 1'b0;
  endtask

  int job_no = 0;

  task automatic run_job(input vec_t w, input vec_t a, input bit ld, input int accum, input int hold);
    longint sum;
    longint exp_res;
    int exp_n;
    int issues = 0;
    int cyc = 1;
    logic [VL-1:0][DW-1:0] act_p;
    logic [VL-1:0] neg_p;
    model_job(w);
    exp_n = q_base.size();
    sum = ld ? longint'(accum) : 0;
    for (int j = 0; j < VL; j++) begin
      sum += longint'(w[j]) * longint'(a[j]);
      act_p[j] = a[j];
      neg_p[j] = (w[j] < 0);
    end
    exp_res = sum & AMASK;
    job_if.out_ready = 1'b0;
    offer_job(w, a, ld, accum);
    while (!job_if.out_valid && cyc < 40) begin
      if (mac_en) begin
        if (q_base.size() > 0) begin
          check_val("issue_base", longint'(mac_shift_2nd_sel), longint'(q_base.pop_front()));
          check_val("issue_en",   longint'(mac_shift_1st_en),  longint'(q_en.pop_front()));
          check_val("issue_sel",  longint'(mac_shift_1st_sel), longint'(q_sel.pop_front()));
        end else begin
          check_val("extra_issue", 1, 0);
        end
        issues++;
      end
      @(negedge clk);
      cyc++;
    end
    check_val("out_valid", longint'(job_if.out_valid), 1);
    check_val("latency", cyc, (exp_n == 0) ? 1 : exp_n + 2);
    check_val("issue_count", issues, exp_n);
    check_val("out_result", longint'(job_if.out_result), exp_res);
    check_val("in_ready_done", longint'(job_if.in_ready), 0);
    check_val("mac_act", longint'(mac_act), longint'(act_p));
    check_val("mac_is_neg", longint'(mac_is_neg), longint'(neg_p));
`ifdef PRAG_CYCLE_CNT_EN
    check_val("out_cycles", longint'(job_if.out_cycles), (exp_n > 15) ? 15 : exp_n);
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_val("hold_valid", longint'(job_if.out_valid), 1);
      check_val("hold_result", longint'(job_if.out_result), exp_res);
      check_val("hold_in_ready", longint'(job_if.in_ready), 0);
      check_val("hold_mac_en", longint'(mac_en), 0);
    end
    job_if.out_ready = 1'b1;
    @(negedge clk);
    job_if.out_ready = 1'b0;
    check_val("post_valid", longint'(job_if.out_valid), 0);
    check_val("post_in_ready", longint'(job_if.in_ready), 1);
    $display("job %0d: issues=%0d result=%0d expected=%0d", job_no, issues,
             $signed(job_if.out_result), $signed(AW'(exp_res)));
    job_no++;
  endtask

  vec_t w, a;

  task automatic clear_vecs();
    for (int j = 0; j < VL; j++) begin
      w[j] = '0;
      a[j] = '0;
    end
  endtask

  initial begin
    job_if.in_valid      = 1'b0;
    job_if.in_weight     = '0;
    job_if.in_act        = '0;
    job_if.in_load_accum = 1'b0;
    job_if.in_accum      = '0;
    job_if.out_ready     = 1'b0;
    #12;
    check_val("rst_in_ready", longint'(job_if.in_ready), 1);
    check_val("rst_out_valid", longint'(job_if.out_valid), 0);
    check_val("rst_out_result", longint'(job_if.out_result), 0);
    check_val("rst_mac_en", longint'(mac_en), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // all-zero weights with preload
    clear_vecs();
    run_job(w, a, 1'b1, 100, 0);
    // single lane, two issues
    clear_vecs(); w[0] = 3; a[0] = 5;
    run_job(w, a, 1'b0, 0, 0);
    // -128 weight isolated at bit 7
    clear_vecs(); w[0] = 1; a[0] = 2; w[1] = -128; a[1] = 3;
    run_job(w, a, 1'b0, 0, 1);
    // window edge: offset 3 fits, offset 4 does not
    clear_vecs(); w[0] = 1; w[1] = 8; a[0] = 1; a[1] = 1;
    run_job(w, a, 1'b0, 0, 0);
    w[1] = 16;
    run_job(w, a, 1'b0, 0, 0);
    // dense weights, held result
    for (int j = 0; j < VL; j++) begin w[j] = 127; a[j] = 1; end
    run_job(w, a, 1'b0, 0, 5);

    // reset during the 3rd issue cycle
    offer_job(w, a, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    check_val("abort_mac_en_before", longint'(mac_en), 1);
    reset_n = 1'b0;
    #1;
    check_val("abort_in_ready", longint'(job_if.in_ready), 1);
    check_val("abort_out_valid", longint'(job_if.out_valid), 0);
    check_val("abort_out_result", longint'(job_if.out_result), 0);
    check_val("abort_mac_en", longint'(mac_en), 0);
    check_val("abort_1st_en", longint'(mac_shift_1st_en), 0);
    check_val("abort_2nd_sel", longint'(mac_shift_2nd_sel), 0);
    check_val("abort_mac_act", longint'(mac_act), 0);
    check_val("abort_is_neg", longint'(mac_is_neg), 0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_vecs(); w[2] = -5; a[2] = 7; w[5] = 66; a[5] = -3;
    run_job(w, a, 1'b1, -10, 0);

    // randomized jobs
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < VL; j++) begin
        case ($urandom_range(0, 3))
          0: w[j] = '0;
          1: begin
            w[j] = DW'(1 << $urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) w[j] = -w[j];
          end
          2: w[j] = DW'($urandom_range(0, 255));
          default: w[j] = ($urandom_range(0, 1) == 1) ? -8'sd128 : 8'sd127;
        endcase
        a[j] = DW'(int'($urandom_range(0, 254)) - 127);
      end
      run_job(w, a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 32'hFFFFFF)),
              int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
